// File: rtl/sqrt_seq_ctrl.sv
// Sequential restoring integer square root: 16-bit radicand -> 8-bit root, 9-bit remainder.
// Latency: start accepted at edge N, done_o and results valid in the cycle after edge N+8.
// Backpressure: none; start_i is ignored while busy_o is high, outputs hold until overwritten.

module cla16 (
    input  logic [15:0] A_i,
    input  logic [15:0] B_i,
    input  logic        Ci_i,
    output logic [15:0] S_o,
    output logic        Co_o
);
    logic [15:0] g, p, c;
    logic [3:0]  gg, pg;
    logic [4:0]  cg;

    always_comb begin
        g  = A_i & B_i;
        p  = A_i ^ B_i;
        gg = '0;
        pg = '0;
        c  = '0;
        cg = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end
        // Second-level lookahead across the four 4-bit groups
        cg[0] = Ci_i;
        cg[1] = gg[0] | (pg[0] & cg[0]);
        cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cg[0]);
        cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & cg[0]);
        cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
              | (pg[3] & pg[2] & pg[1] & gg[0])
              | (pg[3] & pg[2] & pg[1] & pg[0] & cg[0]);
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end
    end

    assign S_o  = p ^ c;
    assign Co_o = cg[4];
endmodule

module sqrt_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   X_i,
    output logic [WIDTH/2-1:0] root_o,
    output logic [WIDTH/2:0]   rem_o,
    output logic               busy_o,
    output logic               done_o
);
    localparam int RW = WIDTH / 2;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] x_q;
    logic [2:0]      cnt_q;
    logic [RW-1:0]   proot_q;
    logic [RW:0]     prem_q;
    logic            accept;

    logic [1:0]      x_pair;
    logic [RW+2:0]   rs;
    logic [RW+1:0]   trial;
    logic [15:0]     cla_a, cla_b, cla_s;
    logic            cla_ci, cla_co;
    logic [RW-1:0]   root_next;
    logic [RW:0]     rem_next;
    logic            unused_cla;

    cla16 u_cla (
        .A_i  (cla_a),
        .B_i  (cla_b),
        .Ci_i (cla_ci),
        .S_o  (cla_s),
        .Co_o (cla_co)
    );

    // Carry-out of rs + ~trial + 1 is the rs >= trial flag; operands are small, so no wrap
    always_comb begin
        x_pair = x_q[{cnt_q, 1'b0} +: 2];
        rs     = {prem_q, x_pair};
        trial  = {proot_q, 2'b01};
        cla_a  = '0;
        cla_b  = '0;
        cla_ci = 1'b0;
        if (state_q == ITER) begin
            cla_a  = {{(WIDTH-RW-3){1'b0}}, rs};
            cla_b  = ~{{(WIDTH-RW-2){1'b0}}, trial};
            cla_ci = 1'b1;
        end
        rem_next  = cla_co ? cla_s[RW:0] : rs[RW:0];
        root_next = {proot_q[RW-2:0], cla_co};
    end

    assign unused_cla = &{1'b0, cla_s[15:RW+1]};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = ITER;
                end
            end
            ITER: begin
                busy_o = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = ITER;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            proot_q <= '0;
            prem_q  <= '0;
            root_o  <= '0;
            rem_o   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_q     <= X_i;
                cnt_q   <= 3'd7;
                proot_q <= '0;
                prem_q  <= '0;
            end else if (state_q == ITER) begin
                proot_q <= root_next;
                prem_q  <= rem_next;
                if (cnt_q != 3'd0) begin
                    cnt_q <= cnt_q - 3'd1;
                end else begin
                    root_o <= root_next;
                    rem_o  <= rem_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Bench for sqrt_seq_ctrl: arithmetic reference model checked every cycle plus literal directed results.
module tb_sqrt_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] x = '0;
    logic [7:0]  root_o;
    logic [8:0]  rem_o;
    logic        busy_o, done_o;

    int tests = 0;
    int fails = 0;

    sqrt_seq_ctrl #(.WIDTH(16)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .X_i     (x),
        .root_o  (root_o),
        .rem_o   (rem_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic isqrt(input int xv, output logic [7:0] r, output logic [8:0] m);
        int rr;
        int rem;
        rr = 0;
        while ((rr + 1) * (rr + 1) <= xv) rr++;
        rem = xv - rr * rr;
        r = rr[7:0];
        m = rem[8:0];
    endtask

    // Reference model: cycles of work left, pending result, visible outputs
    int         m_left = 0;
    bit         m_done = 1'b0;
    logic [7:0] m_root = '0, p_root = '0;
    logic [8:0] m_rem = '0, p_rem = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_root = '0;
            m_rem  = '0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_left == 0) begin
                m_root = p_root;
                m_rem  = p_rem;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_left = 8;
                isqrt(int'(x), p_root, p_rem);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_busy", busy_o, m_left > 0);
            check("model_done", done_o, m_done);
            check("model_root", root_o, m_root);
            check("model_rem",  rem_o,  m_rem);
        end
    end

    // Drives start at the current negedge; returns at the negedge where done_o is seen
    task automatic run_op(input logic [15:0] xv, input logic [7:0] er, input logic [8:0] em,
                          input string nm);
        int n;
        int nbusy;
        bit seen;
        start = 1'b1;
        x     = xv;
        @(negedge clk);
        start = 1'b0;
        x     = 16'h5A5A;
        n     = 1;
        nbusy = 0;
        seen  = 1'b0;
        while (n <= 20 && !seen) begin
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (busy_o) nbusy++;
                @(negedge clk);
                n++;
            end
        end
        check({nm, "_seen"},    seen,   1);
        check({nm, "_latency"}, n,      9);
        check({nm, "_busycyc"}, nbusy,  8);
        check({nm, "_root"},    root_o, er);
        check({nm, "_rem"},     rem_o,  em);
    endtask

    initial begin
        int ndone;
        repeat (2) @(negedge clk);
        check("rst_root", root_o, 0);
        check("rst_rem",  rem_o,  0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        run_op(16'h0000, 8'h00, 9'h000, "x0000");
        @(negedge clk);
        run_op(16'hFFFF, 8'hFF, 9'h1FE, "xFFFF");
        run_op(16'h0090, 8'h0C, 9'h000, "x0090");
        @(negedge clk);
        run_op(16'h0063, 8'h09, 9'h012, "x0063");
        run_op(16'h0002, 8'h01, 9'h001, "x0002");
        run_op(16'h4000, 8'h80, 9'h000, "x4000");
        @(negedge clk);
        @(negedge clk);

        // Start during iteration must be ignored
        start = 1'b1;
        x     = 16'h0063;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        x     = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        x     = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            if (done_o) ndone++;
            @(negedge clk);
        end
        check("ign_dones", ndone,  1);
        check("ign_root",  root_o, 8'h09);
        check("ign_rem",   rem_o,  9'h012);

        // Back-to-back: start held in the DONE cycle
        run_op(16'h0063, 8'h09, 9'h012, "b2b_a");
        run_op(16'h0090, 8'h0C, 9'h000, "b2b_b");
        @(negedge clk);
        run_op(16'hFFFF, 8'hFF, 9'h1FE, "pre_rst");
        @(negedge clk);

        // Asynchronous reset in mid-computation
        start = 1'b1;
        x     = 16'h0090;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_root", root_o, 0);
        check("arst_rem",  rem_o,  0);
        check("arst_busy", busy_o, 0);
        check("arst_done", done_o, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        check("arst_nodone", ndone, 0);
        run_op(16'hFFFF, 8'hFF, 9'h1FE, "post_rst");
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
